// File: rtl/pattern_resp_misr_capture.sv
// Captures a pattern's response vector over a programmed window and compacts it into a MISR signature.
// Optional golden-signature compare is compiled in with MISR_GOLDEN_COMPARE_EN.
module pattern_resp_misr_capture #(
  parameter int RESP_W = 11,
  parameter int SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       window_len,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
`ifdef MISR_GOLDEN_COMPARE_EN
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              match,
`endif
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       vec_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [SIG_W-1:0] sig_reg, sig_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic [15:0]      len_reg, len_next;
  logic             busy_reg, done_reg;
  logic [SIG_W-1:0] sig_step;
  logic [15:0]      cnt_inc;

  assign sig_step = {sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(resp_data);
  // Saturating increment: the count never wraps back to zero
  assign cnt_inc  = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

`ifdef MISR_GOLDEN_COMPARE_EN
  logic [SIG_W-1:0] golden_reg, golden_next;
  logic             match_reg, match_next;
`endif

  always_comb begin
    state_next = state_reg;
    sig_next   = sig_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
`ifdef MISR_GOLDEN_COMPARE_EN
    golden_next = golden_reg;
    match_next  = match_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        // abort takes priority over start; in IDLE it simply leaves everything unchanged
        if (abort && state_reg == DONE) begin
          state_next = IDLE;
`ifdef MISR_GOLDEN_COMPARE_EN
          match_next = 1'b0;
`endif
        end else if (start && !abort) begin
          state_next = RUN;
          sig_next   = SEED;
          cnt_next   = 16'd0;
          len_next   = window_len;
`ifdef MISR_GOLDEN_COMPARE_EN
          golden_next = golden_sig;
          match_next  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
`ifdef MISR_GOLDEN_COMPARE_EN
          match_next = 1'b0;
`endif
        end else if (len_reg == 16'd0) begin
          state_next = DONE;
`ifdef MISR_GOLDEN_COMPARE_EN
          match_next = (sig_reg == golden_reg);
`endif
        end else if (resp_valid) begin
          sig_next = sig_step;
          cnt_next = cnt_inc;
          if (cnt_inc == len_reg) begin
            state_next = DONE;
`ifdef MISR_GOLDEN_COMPARE_EN
            match_next = (sig_step == golden_reg);
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_reg <= IDLE;
      sig_reg   <= '0;
      cnt_reg   <= 16'd0;
      len_reg   <= 16'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sig_reg   <= sig_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
    end
  end

`ifdef MISR_GOLDEN_COMPARE_EN
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      golden_reg <= '0;
      match_reg  <= 1'b0;
    end else begin
      golden_reg <= golden_next;
      match_reg  <= match_next;
    end
  end

  assign match = match_reg;
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign signature = sig_reg;
  assign vec_count = cnt_reg;

endmodule

// File: doc/pattern_resp_misr_capture.md
Name: pattern_resp_misr_capture

Overview:
- Reader side of the merged-pattern netlists. A merged pattern drives a flat vector of registered outputs; this block captures that vector.
- It samples the output vector every valid cycle over a programmed window and compacts it into a 16-bit MISR signature. It also counts the captured vectors.
- It sits in the pattern test harness, downstream of the pattern under test, and feeds the equivalence-check flow.

Parameters:
- RESP_W, 11, width of the captured response vector; must be 1..SIG_W.
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback taps (x^16+x^12+x^5+1).
- SEED, 16'hFFFF, signature value loaded at window start.

Ports:
- blif_clk_net  input  1  single clock; all state updates on rising edge.
- blif_reset_net  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; opens a capture window.
- abort  input  1  terminates an open window early.
- window_len  input  16  number of valid vectors per window; latched on accepted start.
- resp_valid  input  1  resp_data is a valid sample this cycle.
- resp_data  input  RESP_W  output vector from the pattern under test.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- signature  output  SIG_W  current or final MISR value.
- vec_count  output  16  valid vectors compacted in the current or last window.

Behaviour:
- Reset (asynchronous, blif_reset_net=1) forces:
  - state=IDLE
  - signature=0, vec_count=0
  - busy=0, done=0
  - latched length=0
  - match=0 when compiled in
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - start=1 -> RUN next cycle; signature<=SEED, vec_count<=0, len<=window_len.
  - resp_valid is ignored in IDLE.
- RUN:
  - On each cycle with resp_valid=1, one MISR step runs and vec_count increments.
  - MISR step: sig_next = (sig<<1) XOR (sig[SIG_W-1] ? POLY : 0) XOR zero_ext(resp_data).
  - When the valid sample makes vec_count reach len, the next state is DONE. That final sample is included; the signature is frozen from that edge.
  - len=0: first RUN cycle -> DONE with signature=SEED, vec_count=0. No sample is taken, even if resp_valid=1.
  - abort=1 -> IDLE next cycle. signature and vec_count hold their last values; done is not asserted. A sample valid in the abort cycle is discarded.
  - abort and resp_valid together: abort wins.
  - start during RUN is ignored; window_len changes are ignored.
- DONE:
  - done=1, and signature and vec_count hold until start or abort.
  - start=1 -> RUN with reload, as from IDLE.
  - abort=1 -> IDLE.
  - start and abort together in DONE: abort wins.
- Latency: a sample valid on edge N is reflected in signature after edge N. done rises on the edge that consumes the final sample.
- vec_count saturates at 16'hFFFF and never wraps. len cannot exceed this.
- A reset asserted mid-window discards the window. Operation restarts from IDLE after reset is released.

Optional Feature:
- Macro: MISR_GOLDEN_COMPARE_EN.
- When defined:
  - Adds input golden_sig[SIG_W-1:0] and output match.
  - golden_sig is latched on accepted start.
  - match is registered. It goes to 1 on the edge that enters DONE if the final signature equals the latched golden value, else 0.
  - match clears to 0 on start, abort and reset, and holds while in DONE.
- When undefined: no golden_sig or match port and no compare logic. All other behaviour is identical.

Test Plan:
- Single vector: reset, start with window_len=1, then resp_valid=1 with resp_data=11'h001 -> signature=16'hEFDE, vec_count=1, done=1 on the next cycle; busy=0.
- Two vectors with a gap: window_len=2; samples 11'h001, then resp_valid=0 for 3 cycles, then 11'h000 -> signature=16'hCF9D, vec_count=2. The signature is unchanged during the idle cycles.
- Zero-length window: window_len=0, start, with resp_valid held at 1 -> DONE after one RUN cycle; signature=16'hFFFF, vec_count=0.
- Abort and ignore rules:
  - window_len=5; abort after 3 valid samples, asserted together with a 4th valid sample -> IDLE; vec_count=3; done=0.
  - start pulsed in RUN -> no reload.
- Asynchronous reset mid-RUN after 2 samples -> all outputs 0 immediately, without waiting for a clock edge. A new start afterwards yields the same signature as a clean run.
- MISR_GOLDEN_COMPARE_EN:
  - golden_sig=16'hEFDE with the single-vector stimulus -> match=1 with done.
  - golden_sig=16'h0000 -> match=0.
  - match clears on the next start.
